// File: rtl/chan_stream_mux.sv
// Multi-channel stream mux with static or round-robin channel selection
// feeding a single registered output beat with valid/ready handshake.
module chan_stream_mux #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic [SELW-1:0]      out_chan,
  input  logic                 out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              load;
  logic              xfer;
  logic              gnt_vld;
  logic [SELW-1:0]   gnt_idx;
  logic [WIDTH-1:0]  gnt_data;
  logic [SELW-1:0]   ptr;
  int                k;

  // Static mode grants sel only when it names a real channel.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    k       = 0;
    if (mode) begin
      for (int i = 0; i < NCH; i++) begin
        k = (int'(ptr) + 1 + i) % NCH;
        if (!gnt_vld && in_valid[k]) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(k);
        end
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (sel == SELW'(c)) begin
          gnt_vld = in_valid[c];
          gnt_idx = sel;
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int c = 0; c < NCH; c++) begin
      if (gnt_idx == SELW'(c)) begin
        gnt_data = in_data[c*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    load      = (state == EMPTY) | out_ready;
    xfer      = load & gnt_vld;
    state_nxt = state;
    in_ready  = '0;
    for (int c = 0; c < NCH; c++) begin
      in_ready[c] = rst_n & xfer & (gnt_idx == SELW'(c));
    end
    if (load) begin
      state_nxt = gnt_vld ? FULL : EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_chan <= '0;
      ptr      <= SELW'(NCH - 1);
    end else if (xfer) begin
      out_data <= gnt_data;
      out_chan <= gnt_idx;
      if (mode) begin
        ptr <= gnt_idx;
      end
    end
  end

  assign out_valid = (state == FULL);

endmodule

// File: tb/tb_chan_stream_mux.sv
// Scoreboard bench for chan_stream_mux: directed static, backpressure,
// round-robin, idle and mid-stream reset sequences.
module tb_chan_stream_mux;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  out_data;
  logic        out_valid;
  logic [1:0]  out_chan;
  logic        out_ready;

  typedef struct {
    logic [3:0] d;
    logic [1:0] c;
  } exp_t;

  exp_t q[$];
  int checks;
  int failures;

  chan_stream_mux #(.WIDTH(4), .NCH(4), .SELW(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mode(mode),
    .sel(sel),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_chan(out_chan),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] d, input logic [1:0] c);
    exp_t e;
    e.d = d;
    e.c = c;
    q.push_back(e);
  endtask

  // Monitor: every accepted output beat must match the next expected one.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", {28'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("sb_data", {28'd0, out_data}, {28'd0, e.d});
        chk("sb_chan", {30'd0, out_chan}, {30'd0, e.c});
      end
    end
  end

  logic [1:0] rr_seq [7];
  logic [1:0] wr_seq [3];

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_data   = 16'h0000;
    in_valid  = 4'b1111;
    mode      = 1'b1;
    sel       = 2'd0;
    out_ready = 1'b1;
    rr_seq    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    wr_seq    = '{2'd0, 2'd1, 2'd0};
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {28'd0, out_data}, 32'd0);
    chk("rst_out_chan", {30'd0, out_chan}, 32'd0);
    chk("rst_in_ready", {28'd0, in_ready}, 32'd0);
    step();
    step();
    rst_n    = 1'b1;
    in_valid = 4'b0000;

    // static select of channel 2
    mode     = 1'b0;
    sel      = 2'd2;
    in_valid = 4'b0100;
    in_data[8 +: 4] = 4'hA;
    push(4'hA, 2'd2);
    #2;
    chk("static_in_ready", {28'd0, in_ready}, 32'b0100);
    step();
    chk("static_valid", {31'd0, out_valid}, 32'd1);
    chk("static_data", {28'd0, out_data}, 32'hA);
    chk("static_chan", {30'd0, out_chan}, 32'd2);

    // backpressure: held beat must not be overwritten
    out_ready = 1'b0;
    in_data[8 +: 4] = 4'h5;
    #2;
    chk("bp_in_ready", {28'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_data", {28'd0, out_data}, 32'hA);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_ready", {28'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    push(4'h5, 2'd2);
    #2;
    chk("bp_refill_ready", {28'd0, in_ready}, 32'b0100);
    step();
    chk("bp_refill_data", {28'd0, out_data}, 32'h5);
    in_valid = 4'b0000;
    step();

    // static idle: selected channel not valid
    sel      = 2'd1;
    in_valid = 4'b1101;
    #2;
    chk("idle_in_ready", {28'd0, in_ready}, 32'd0);
    step();
    chk("idle_valid", {31'd0, out_valid}, 32'd0);

    // round-robin from reset pointer, then skip/wrap with pointer=2
    mode     = 1'b1;
    in_data  = 16'h4321;
    in_valid = 4'b1111;
    for (int i = 0; i < 7; i++) push(4'(rr_seq[i] + 1), rr_seq[i]);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("rr_chan", {30'd0, out_chan}, {30'd0, rr_seq[i]});
      chk("rr_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 4'b0011;
    for (int i = 0; i < 3; i++) push(4'(wr_seq[i] + 1), wr_seq[i]);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wrap_chan", {30'd0, out_chan}, {30'd0, wr_seq[i]});
    end
    in_valid = 4'b0000;
    step();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    // reset mid-stream discards a held beat
    out_ready = 1'b0;
    mode      = 1'b0;
    sel       = 2'd0;
    in_valid  = 4'b0001;
    in_data   = 16'h8007;
    step();
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    mode     = 1'b1;
    in_valid = 4'b1000;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {28'd0, in_ready}, 32'd0);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    push(4'h8, 2'd3);
    #2;
    chk("post_rst_ready", {28'd0, in_ready}, 32'b1000);
    step();
    chk("post_rst_chan", {30'd0, out_chan}, 32'd3);
    chk("post_rst_data", {28'd0, out_data}, 32'h8);
    in_valid = 4'b0000;
    step();
    step();
    chk("sb_empty", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chan_stream_mux.md
CHAN_STREAM_MUX -- requirements
Module: chan_stream_mux

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, meaning data bits per channel (WIDTH >= 1).
REQ-002 The module SHALL have parameter NCH, default 4, meaning number of input channels (NCH >= 2).
REQ-003 The module SHALL have parameter SELW, default 2, meaning select/channel-index width; SELW >= ceil(log2(NCH)).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_data  input  NCH*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 in_valid  input  NCH  per-channel valid.
REQ-008 in_ready  output  NCH  per-channel ready; at most one bit high per cycle.
REQ-009 mode  input  1  0 = static select, 1 = round-robin scan.
REQ-010 sel  input  SELW  channel index used in static mode.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_valid  output  1  out_data holds a valid beat.
REQ-013 out_chan  output  SELW  index of the channel that produced out_data.
REQ-014 out_ready  input  1  downstream accepts the beat when out_valid & out_ready.

Function
REQ-015 Channel k transfer SHALL occur in a cycle where in_valid[k] & in_ready[k] are high; output transfer where out_valid & out_ready are high.
REQ-016 Output stage SHALL be a single register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 load SHALL be asserted when state is EMPTY, or FULL with out_ready=1 (same-cycle drain and refill permitted).
REQ-018 Static mode: grant = sel when sel < NCH and in_valid[sel]=1; otherwise no grant.
REQ-019 Static mode with sel >= NCH SHALL grant nothing, leaving all in_ready low.
REQ-020 Round-robin mode: grant SHALL be the first k with in_valid[k]=1, searching from (last+1) mod NCH upward with wrap-around, where last is the round-robin pointer.
REQ-021 The round-robin pointer SHALL update to the granted index only on a round-robin-mode input transfer; static-mode transfers SHALL NOT move it.
REQ-022 in_ready[g] SHALL equal load for the granted channel g, and 0 for all other channels; in_ready is combinational from state, out_ready, mode, sel, in_valid.
REQ-023 On an input transfer, next cycle SHALL show out_data = channel g data, out_chan = g, out_valid = 1 (latency exactly 1 cycle).
REQ-024 On load with no grant, out_valid SHALL go to 0 next cycle (FULL -> EMPTY if drained); with no load, out_data/out_chan/out_valid SHALL hold.
REQ-025 While FULL and out_ready=0, out_data and out_chan SHALL remain stable; no beat is dropped or overwritten.
REQ-026 Change of mode or sel SHALL affect only subsequent grants; a held output beat SHALL be unaffected.
REQ-027 Throughput SHALL be one beat per cycle when out_ready is held high and a grant exists each cycle.

Reset
REQ-028 While rst_n=0, out_valid SHALL be 0, out_data 0, out_chan 0, and the round-robin pointer NCH-1 (so channel 0 has first round-robin priority), independent of clk.
REQ-029 in_ready SHALL be all-zero while rst_n=0.
REQ-030 Reset asserted mid-operation SHALL discard any held beat; the first post-reset load behaves as from EMPTY.

Verification (WIDTH=4, NCH=4, SELW=2)
REQ-031 Static: mode=0, sel=2, in_valid=4'b0100, ch2=4'hA, out_ready=1 -> in_ready=4'b0100; next cycle out_data=4'hA, out_chan=2, out_valid=1.
REQ-032 Backpressure: FULL with out_data=4'hA, out_ready=0 for 3 cycles, ch2 changes to 4'h5 -> in_ready=0, out_data stays 4'hA; on out_ready=1, ch2 beat 4'h5 loads the next cycle.
REQ-033 Round-robin: after reset, mode=1, in_valid=4'b1111, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles.
REQ-034 Round-robin skip/wrap: pointer=2, in_valid=4'b0011 -> grant channel 0, then channel 1, then channel 0.
REQ-035 Reset mid-stream: out_valid=1, rst_n pulled low between clock edges -> out_valid=0 and in_ready=0 immediately; after release with mode=1, in_valid=4'b1000, first grant is channel 3.
REQ-036 Static idle: mode=0, sel=1, in_valid=4'b1101 -> no grant, in_ready=0; after draining, out_valid=0.
